// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed seven-segment driver: shadows d1..d6 with optional
// leading-zero blanking and scans one digit per DIV clock cycles.
module seg7_scan_driver #(
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic       blank_lz,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [5:0]    AN_OFF  = SEG_ACTIVE_LOW ? 6'b111111 : 6'b000000;
  localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic [3:0]    shadow_q [6];
  logic [3:0]    shadow_d [6];
  logic [3:0]    raw      [6];
  logic [5:0]    an_q;
  logic [6:0]    seg_q;
  logic          frame_done_q;
  logic          tick;
  logic          lz_run;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = 7'h3F;
      4'h1:    decode = 7'h06;
      4'h2:    decode = 7'h5B;
      4'h3:    decode = 7'h4F;
      4'h4:    decode = 7'h66;
      4'h5:    decode = 7'h6D;
      4'h6:    decode = 7'h7D;
      4'h7:    decode = 7'h07;
      4'h8:    decode = 7'h7F;
      4'h9:    decode = 7'h6F;
      4'hA:    decode = 7'h40;
      default: decode = 7'h00;
    endcase
  endfunction

  assign tick  = (cnt_q == CNT_MAX);
  assign idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

  // Blanking is resolved at capture time; non-digit codes neither blank nor end the run.
  always_comb begin
    raw[0] = d1;
    raw[1] = d2;
    raw[2] = d3;
    raw[3] = d4;
    raw[4] = d5;
    raw[5] = d6;
    lz_run = blank_lz;
    for (int i = 0; i < 5; i++) begin
      shadow_d[i] = raw[i];
      if (lz_run && raw[i] == 4'h0) begin
        shadow_d[i] = 4'hF;
      end else if (raw[i] >= 4'h1 && raw[i] <= 4'h9) begin
        lz_run = 1'b0;
      end
    end
    shadow_d[5] = raw[5];
  end

  // The tick reads shadow_q before any same-edge load lands, so a coincident
  // load only becomes visible from the following digit slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 3'd5;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= 4'hF;
    end else begin
      cnt_q        <= tick ? '0 : cnt_q + CW'(1);
      frame_done_q <= tick && (idx_d == 3'd5);
      if (tick) begin
        idx_q <= idx_d;
        an_q  <= (6'd1 << idx_d) ^ AN_OFF;
        seg_q <= decode(shadow_q[idx_d]) ^ SEG_OFF;
      end
      if (load) begin
        for (int i = 0; i < 6; i++) shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model pushes
// the expected outputs after every edge and a negedge monitor checks them.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d1 = 4'h0, d2 = 4'h0, d3 = 4'h0, d4 = 4'h0, d5 = 4'h0, d6 = 4'h0;
  logic       blank_lz = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       frame_done;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;

  // Model state: edges since last reset edge, shadow digits, held outputs.
  int         n = 0;
  logic [3:0] msh [6];
  exp_t       cur;

  seg7_scan_driver #(.DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .blank_lz(blank_lz), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segPattern(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
      4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
      4'h9: return 7'h6F;  4'hA: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  // Model of one clock edge given the inputs the DUT sampled there.
  task automatic modelEdge(input logic rst, input logic ld, input logic [23:0] digs, input logic blz);
    logic [3:0] c [6];
    bit         leading;
    int         k;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 6; i++) msh[i] = 4'hF;
      cur = '{an: 6'b111111, seg: 7'h7F, fd: 1'b0};
    end else begin
      n++;
      cur.fd = 1'b0;
      if (n % DIV == 0) begin
        k = (n / DIV - 1) % 6;
        cur.an  = ~(6'd1 << k);
        cur.seg = ~segPattern(msh[k]);
        cur.fd  = (k == 5);
      end
      if (ld) begin
        for (int i = 0; i < 6; i++) c[i] = digs[23 - 4*i -: 4];
        leading = blz;
        for (int i = 0; i < 6; i++) begin
          if (i < 5 && leading && c[i] == 4'h0) msh[i] = 4'hF;
          else msh[i] = c[i];
          if (c[i] >= 1 && c[i] <= 9) leading = 0;
        end
      end
    end
    expQ.push_back(cur);
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic [23:0] digs, input logic blz);
    #1;
    reset = rst; load = ld; blank_lz = blz;
    {d1, d2, d3, d4, d5, d6} = digs;
    @(posedge clk);
    modelEdge(rst, ld, digs, blz);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 24'hFFFFFF, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (an !== e.an || seg !== e.seg || frame_done !== e.fd) begin
      mismatched++;
      $display("[TB] FAIL scan n=%0d: got an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
               n, an, seg, frame_done, e.an, e.seg, e.fd);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    logic [23:0] digs;
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    idle(30);

    applyStimulus(1'b1, 1'b1, 24'h000123, 1'b0);
    applyStimulus(1'b0, 1'b1, 24'h000123, 1'b0);
    idle(60);

    applyStimulus(1'b0, 1'b1, 24'hA00007, 1'b1);
    idle(30);
    applyStimulus(1'b0, 1'b1, 24'h000000, 1'b1);
    idle(30);

    // Load lands exactly on a tick edge: that slot must still show the old 1s.
    applyStimulus(1'b0, 1'b1, 24'h111111, 1'b0);
    while ((n + 1) % DIV != 0) idle(1);
    applyStimulus(1'b0, 1'b1, 24'h888888, 1'b0);
    idle(30);

    // Reset while d3 is lit.
    while (!(n >= DIV && (n / DIV - 1) % 6 == 2 && n % DIV == 1)) idle(1);
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    idle(DIV + 4);

    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 6; j++)
        digs[23 - 4*j -: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), digs,
                    1'($urandom_range(0, 1)));
    end

    for (int w = 0; w < 4 && expQ.size() > 0; w++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
